// File: rtl/line_buf_sched_pkg.sv
// Shared frame-buffer geometry and the per-row-buffer state encoding used by
// the line buffer scheduler and its renderer interface.
package line_buf_sched_pkg;

    localparam int unsigned FB_DEPTH      = 2;
    localparam int unsigned Y_WIDTH       = 600;
    localparam int unsigned X_WIDTH       = 800;
    localparam int unsigned FB_ADDR_WIDTH = $clog2(X_WIDTH);
    localparam int unsigned FB_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_FILLING,
        BUF_FULL,
        BUF_READING
    } buf_state_e;

endpackage

// File: rtl/fb_if.sv
// Renderer pixel stream: one pixel per cycle plus end-of-row / end-of-frame marks.
interface fb_if
    import line_buf_sched_pkg::*;
#(
    parameter int unsigned AW = FB_ADDR_WIDTH,
    parameter int unsigned DW = FB_DATA_WIDTH
);
    logic          vld;
    logic [AW-1:0] x_coord;
    logic [DW-1:0] val;
    logic          row_done;
    logic          frame_done;

    modport producer (output vld, x_coord, val, row_done, frame_done);
    modport consumer (input  vld, x_coord, val, row_done, frame_done);
endinterface

// File: rtl/ring_ptr.sv
// Modulo-DEPTH ring pointer that steps by one when i_adv is high.
module ring_ptr #(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned BW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_adv,
    output logic [BW-1:0] o_ptr
);

    logic [BW-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_adv) begin
            r_ptr <= (r_ptr == BW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/line_buf_sched.sv
// Row-buffer ring scheduler between a pixel renderer and a VGA line reader;
// storage is external, this block only hands out buffer indices and status.
module line_buf_sched
    import line_buf_sched_pkg::*;
#(
    parameter  int unsigned DEPTH = FB_DEPTH,
    parameter  int unsigned ROWS  = Y_WIDTH,
    parameter  int unsigned COLS  = X_WIDTH,
    localparam int unsigned BW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned RW    = $clog2(ROWS),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fb_if.consumer                   fb,
    output logic                     wr_rdy,
    output logic                     wr_en,
    output logic [BW-1:0]            wr_buf,
    output logic [FB_ADDR_WIDTH-1:0] wr_addr,
    input  logic                     line_req,
    input  logic                     line_rel,
    output logic [BW-1:0]            rd_buf,
    output logic                     rd_vld,
    output logic                     underrun,
    output logic                     frame_err,
    output logic [RW-1:0]            row_cnt
);

    if (COLS > (1 << FB_ADDR_WIDTH)) begin : g_cols_chk
        $error("COLS does not fit in FB_ADDR_WIDTH");
    end

    logic [CW-1:0] r_count;
    buf_state_e    r_state [DEPTH];
    logic [RW-1:0] r_row_cnt;
    logic          r_underrun;
    logic          r_frame_err;

    logic [BW-1:0] w_wr_ptr;
    logic [BW-1:0] w_rd_ptr;
    logic          w_reading;
    logic          w_row_acc;
    logic          w_req_acc;
    logic          w_rel_acc;
    logic          w_underrun_evt;
    logic          w_frame_evt;
    logic [RW-1:0] w_row_cnt_nxt;

    ring_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_adv (w_row_acc),
        .o_ptr (w_wr_ptr)
    );

    ring_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_adv (w_rel_acc),
        .o_ptr (w_rd_ptr)
    );

    always_comb begin
        wr_rdy         = (r_count < CW'(DEPTH));
        wr_en          = fb.vld & wr_rdy & rst_n;
        w_reading      = (r_state[w_rd_ptr] == BUF_READING);
        w_row_acc      = fb.row_done & wr_rdy;
        w_req_acc      = line_req & (r_count != '0) & ~w_reading;
        w_rel_acc      = line_rel & w_reading;
        w_underrun_evt = line_req & (r_count == '0);
        w_frame_evt    = 1'b0;
        w_row_cnt_nxt  = r_row_cnt;
        // Both a misplaced frame_done and a missing one end the frame at zero.
        if (w_row_acc) begin
            if (fb.frame_done) begin
                w_row_cnt_nxt = '0;
                w_frame_evt   = (r_row_cnt != RW'(ROWS - 1));
            end else if (r_row_cnt == RW'(ROWS - 1)) begin
                w_row_cnt_nxt = '0;
                w_frame_evt   = 1'b1;
            end else begin
                w_row_cnt_nxt = r_row_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_row_cnt   <= '0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_state[i] <= BUF_EMPTY;
            end
        end else begin
            case ({w_row_acc, w_rel_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Write and read sides only touch the same index when count is 0 or DEPTH,
            // where the opposite side is blocked, so these updates never collide.
            if (wr_en && r_state[w_wr_ptr] == BUF_EMPTY) r_state[w_wr_ptr] <= BUF_FILLING;
            if (w_row_acc) r_state[w_wr_ptr] <= BUF_FULL;
            if (w_req_acc) r_state[w_rd_ptr] <= BUF_READING;
            if (w_rel_acc) r_state[w_rd_ptr] <= BUF_EMPTY;
            r_row_cnt   <= w_row_cnt_nxt;
            r_underrun  <= r_underrun | w_underrun_evt;
            r_frame_err <= r_frame_err | w_frame_evt;
        end
    end

    assign wr_buf    = w_wr_ptr;
    assign wr_addr   = fb.x_coord;
    assign rd_buf    = w_rd_ptr;
    assign rd_vld    = w_reading;
    assign underrun  = r_underrun;
    assign frame_err = r_frame_err;
    assign row_cnt   = r_row_cnt;

endmodule

// File: tb/tb_line_buf_sched.sv
// Scoreboard bench for line_buf_sched: directed stimulus queues expected status
// snapshots and buffer writes; a negedge monitor pops and compares them.
module tb_line_buf_sched;
    import line_buf_sched_pkg::*;

    localparam int unsigned BW = 1;
    localparam int unsigned RW = 10;
    localparam int unsigned AW = FB_ADDR_WIDTH;

    typedef struct packed {
        logic          rdy;
        logic [BW-1:0] wb;
        logic [BW-1:0] rb;
        logic          rv;
        logic          un;
        logic          fe;
        logic [RW-1:0] rc;
    } stat_t;

    typedef struct packed {
        int    id;
        stat_t st;
    } snap_t;

    typedef struct packed {
        logic [BW-1:0] b;
        logic [AW-1:0] a;
    } wr_t;

    logic          clk;
    logic          rst_n;
    logic          wr_rdy, wr_en, rd_vld, underrun, frame_err;
    logic [BW-1:0] wr_buf, rd_buf;
    logic [AW-1:0] wr_addr;
    logic          line_req, line_rel;
    logic [RW-1:0] row_cnt;

    fb_if #(.AW(AW), .DW(FB_DATA_WIDTH)) fb_bus ();

    line_buf_sched #(.DEPTH(2), .ROWS(600), .COLS(800)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fb        (fb_bus),
        .wr_rdy    (wr_rdy),
        .wr_en     (wr_en),
        .wr_buf    (wr_buf),
        .wr_addr   (wr_addr),
        .line_req  (line_req),
        .line_rel  (line_rel),
        .rd_buf    (rd_buf),
        .rd_vld    (rd_vld),
        .underrun  (underrun),
        .frame_err (frame_err),
        .row_cnt   (row_cnt)
    );

    snap_t exp_q [$];
    wr_t   wr_q  [$];
    int    n_chk = 0;
    int    n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            n_chk++;
            if (wr_q.size() == 0) begin
                n_err++;
                $display("FAIL write_unexpected: got buf=%0d addr=%0d, required no write", wr_buf, wr_addr);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                if (wr_buf !== w.b || wr_addr !== w.a) begin
                    n_err++;
                    $display("FAIL write: got buf=%0d addr=%0d, required buf=%0d addr=%0d",
                             wr_buf, wr_addr, w.b, w.a);
                end
            end
        end
        if (exp_q.size() != 0) begin
            snap_t s;
            stat_t act;
            s   = exp_q.pop_front();
            act = '{rdy: wr_rdy, wb: wr_buf, rb: rd_buf, rv: rd_vld,
                    un: underrun, fe: frame_err, rc: row_cnt};
            n_chk++;
            if (act !== s.st) begin
                n_err++;
                $display("FAIL snap%0d: got rdy=%0b wb=%0d rb=%0d rv=%0b un=%0b fe=%0b rc=%0d, required rdy=%0b wb=%0d rb=%0d rv=%0b un=%0b fe=%0b rc=%0d",
                         s.id, act.rdy, act.wb, act.rb, act.rv, act.un, act.fe, act.rc,
                         s.st.rdy, s.st.wb, s.st.rb, s.st.rv, s.st.un, s.st.fe, s.st.rc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        fb_bus.vld        = 1'b0;
        fb_bus.row_done   = 1'b0;
        fb_bus.frame_done = 1'b0;
        line_req          = 1'b0;
        line_rel          = 1'b0;
    endtask

    task automatic chk(input int id, input logic rdy, input logic [BW-1:0] wb,
                       input logic [BW-1:0] rb, input logic rv, input logic un,
                       input logic fe, input logic [RW-1:0] rc);
        snap_t s;
        s.id = id;
        s.st = '{rdy: rdy, wb: wb, rb: rb, rv: rv, un: un, fe: fe, rc: rc};
        exp_q.push_back(s);
        tick();
    endtask

    task automatic pixel(input int x, input logic [BW-1:0] b);
        wr_t w;
        fb_bus.vld     = 1'b1;
        fb_bus.x_coord = AW'(x);
        fb_bus.val     = FB_DATA_WIDTH'(x);
        w.b = b;
        w.a = AW'(x);
        wr_q.push_back(w);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic row_cycle(input logic fd);
        fb_bus.row_done   = 1'b1;
        fb_bus.frame_done = fd;
        tick();
        line_req = 1'b1;
        tick();
        line_rel = 1'b1;
        tick();
    endtask

    initial begin
        rst_n             = 1'b0;
        fb_bus.vld        = 1'b0;
        fb_bus.x_coord    = '0;
        fb_bus.val        = '0;
        fb_bus.row_done   = 1'b0;
        fb_bus.frame_done = 1'b0;
        line_req          = 1'b0;
        line_rel          = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // underrun at empty ring, then row_done and line_req together
        chk(1, 1, 0, 0, 0, 0, 0, 0);
        line_req = 1'b1; tick();
        chk(2, 1, 0, 0, 0, 1, 0, 0);
        fb_bus.row_done = 1'b1; line_req = 1'b1; tick();
        chk(3, 1, 1, 0, 0, 1, 0, 1);
        line_req = 1'b1; tick();
        chk(4, 1, 1, 0, 1, 1, 0, 1);
        line_rel = 1'b1; tick();
        chk(5, 1, 1, 1, 0, 1, 0, 1);

        // full 800-pixel row, last pixel shares the row_done cycle
        do_reset();
        chk(6, 1, 0, 0, 0, 0, 0, 0);
        for (int x = 0; x < 799; x++) begin
            pixel(x, 0); tick();
        end
        pixel(799, 0); fb_bus.row_done = 1'b1; tick();
        chk(7, 1, 1, 0, 0, 0, 0, 1);

        // second row fills the ring; third row is blocked
        for (int x = 0; x < 3; x++) begin
            pixel(x, 1); tick();
        end
        pixel(3, 1); fb_bus.row_done = 1'b1; tick();
        chk(8, 0, 0, 0, 0, 0, 0, 2);
        fb_bus.vld = 1'b1; fb_bus.x_coord = AW'(5); fb_bus.row_done = 1'b1; tick();
        chk(9, 0, 0, 0, 0, 0, 0, 2);

        line_req = 1'b1; tick();
        chk(10, 0, 0, 0, 1, 0, 0, 2);
        fb_bus.row_done = 1'b1; tick();
        chk(11, 0, 0, 0, 1, 0, 0, 2);
        line_rel = 1'b1; tick();
        chk(12, 1, 0, 1, 0, 0, 0, 2);
        line_req = 1'b1; tick();
        chk(13, 1, 0, 1, 1, 0, 0, 2);
        pixel(7, 0); fb_bus.row_done = 1'b1; line_rel = 1'b1; tick();
        chk(14, 1, 1, 0, 0, 0, 0, 3);

        // reset in the middle of a row with one full buffer held
        for (int x = 0; x < 400; x++) begin
            pixel(x, 1); tick();
        end
        fb_bus.vld = 1'b1; fb_bus.x_coord = AW'(400); rst_n = 1'b0; tick();
        rst_n = 1'b1;
        chk(15, 1, 0, 0, 0, 0, 0, 0);
        line_req = 1'b1; tick();
        chk(16, 1, 0, 0, 0, 1, 0, 0);
        do_reset();
        chk(17, 1, 0, 0, 0, 0, 0, 0);

        // frame accounting
        for (int r = 0; r < 599; r++) row_cycle(1'b0);
        chk(18, 1, 1, 1, 0, 0, 0, 599);
        row_cycle(1'b1);
        chk(19, 1, 0, 0, 0, 0, 0, 0);
        for (int r = 0; r < 10; r++) row_cycle(1'b0);
        chk(20, 1, 0, 0, 0, 0, 0, 10);
        row_cycle(1'b1);
        chk(21, 1, 1, 1, 0, 0, 1, 0);
        do_reset();
        chk(22, 1, 0, 0, 0, 0, 0, 0);
        for (int r = 0; r < 600; r++) row_cycle(1'b0);
        chk(23, 1, 0, 0, 0, 0, 1, 0);

        tick();
        tick();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL snap_drain: got %0d pending, required 0", exp_q.size());
        end
        n_chk++;
        if (wr_q.size() != 0) begin
            n_err++;
            $display("FAIL write_drain: got %0d missing writes, required 0", wr_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/line_buf_sched.md
LINE_BUF_SCHED -- requirements
Module: line_buf_sched

Interface
REQ-001 SHALL have parameter DEPTH, default `FB_DEPTH (2): number of row buffers.
REQ-002 SHALL have parameter ROWS, default `Y_WIDTH (600): rows per frame.
REQ-003 SHALL have parameter COLS, default `X_WIDTH (800): pixels per row.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 fb  fb_if (producer side, in)  renderer stream: vld, x_coord, val, row_done, frame_done.
REQ-007 wr_rdy  out  1  renderer may present pixels/row_done this cycle.
REQ-008 wr_en  out  1  buffer write strobe.
REQ-009 wr_buf  out  $clog2(DEPTH)  buffer index written.
REQ-010 wr_addr  out  `FB_ADDR_WIDTH  column written, = fb.x_coord.
REQ-011 line_req  in  1  VGA side pulse: next display line needed.
REQ-012 line_rel  in  1  VGA side pulse: current line fully scanned out.
REQ-013 rd_buf  out  $clog2(DEPTH)  buffer index VGA reads.
REQ-014 rd_vld  out  1  rd_buf holds a valid complete row.
REQ-015 underrun  out  1  sticky: line_req with no full buffer.
REQ-016 frame_err  out  1  sticky: frame_done not aligned with row ROWS-1.
REQ-017 row_cnt  out  $clog2(ROWS)  rows completed by renderer this frame.

Function
REQ-018 SHALL manage DEPTH buffers as a ring: wr_ptr, rd_ptr, occupancy count 0..DEPTH.
REQ-019 wr_rdy SHALL be 1 iff count < DEPTH; combinational from registered state.
REQ-020 wr_en SHALL equal fb.vld & wr_rdy, same cycle; wr_buf = wr_ptr.
REQ-021 fb.vld with wr_rdy=0 SHALL be ignored (no write, no state change).
REQ-022 fb.row_done & wr_rdy SHALL, next cycle: count+1, wr_ptr advance mod DEPTH, row_cnt+1.
REQ-023 Pixel on same cycle as row_done SHALL be written to the old wr_ptr before advance.
REQ-024 Per-buffer state SHALL be EMPTY -> FILLING (first write) -> FULL (row_done) -> READING (line_req) -> EMPTY (line_rel).
REQ-025 line_req with count>0 and not READING SHALL set READING, rd_vld=1 next cycle, rd_buf=rd_ptr.
REQ-026 line_req with count=0 SHALL set underrun, leave rd_vld=0, and not change pointers.
REQ-027 line_rel while READING SHALL, next cycle: count-1, rd_ptr advance mod DEPTH, rd_vld=0.
REQ-028 line_rel while not READING SHALL be ignored.
REQ-029 line_req while already READING SHALL be ignored.
REQ-030 Simultaneous accepted row_done and line_rel SHALL leave count unchanged, advance both pointers.
REQ-031 Simultaneous line_req and row_done at count=0 SHALL flag underrun; row becomes FULL normally.
REQ-032 fb.frame_done with accepted row_done SHALL reset row_cnt to 0 instead of incrementing.
REQ-033 frame_done when row_cnt != ROWS-1, or row_cnt reaching ROWS without frame_done, SHALL set frame_err and wrap row_cnt to 0.
REQ-034 Pointer wrap SHALL be modulo DEPTH; count SHALL never exceed DEPTH or go negative.
REQ-035 underrun and frame_err SHALL clear only on reset.

Reset
REQ-036 On rst_n=0 at clk edge: count=0, wr_ptr=rd_ptr=0, all buffers EMPTY, row_cnt=0.
REQ-037 Reset outputs: wr_rdy=1, wr_en=0 (fb.vld gated), wr_buf=0, rd_buf=0, rd_vld=0, underrun=0, frame_err=0.
REQ-038 Reset mid-row or mid-line SHALL discard all buffer contents and partial rows.

Structure
REQ-039 Buffer state enum (EMPTY/FILLING/FULL/READING) SHALL live in the shared defines header with `FB_DEPTH.
REQ-040 SHALL contain no RAM; buffer storage is external, addressed by wr_buf/wr_addr and rd_buf.
REQ-041 One sub-module natural: ring_ptr (mod-DEPTH pointer with advance enable), instantiated twice.

Verification
REQ-042 Reset, 800 px + row_done -> count=1, wr_buf=1, row_cnt=1, wr_rdy=1.
REQ-043 Two rows, no line_req -> wr_rdy=0; third row's vld produces no wr_en.
REQ-044 line_req at count=0 -> underrun=1, rd_vld=0; later row_done then line_req -> rd_vld=1, rd_buf=0.
REQ-045 count=2 READING, row_done blocked; line_rel -> count=1, rd_ptr=1, wr_rdy=1; row_done+line_rel same cycle -> count=1.
REQ-046 600 rows with frame_done on row 599 -> row_cnt=0, frame_err=0; frame_done on row 10 -> frame_err=1.
REQ-047 rst_n=0 at pixel 400, count=1 -> all outputs at reset values next cycle.
